// File: rtl/ddr5_req_queue.sv
// ============================================================================
// ddr5_req_queue : in-order request FIFO in front of the DDR5 controller,
//                  with read-response return and per-transaction timeout.
// Revision 1.0
// ============================================================================
`default_nettype none

module ddr5_req_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 20,
  parameter int DEPTH      = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic                      req_we,
  input  logic [DATA_WIDTH-1:0]     req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic                      mc_valid,
  output logic [ADDR_WIDTH-1:0]     mc_addr,
  output logic                      mc_we,
  output logic [DATA_WIDTH-1:0]     mc_wdata,
  input  logic                      mc_done,
  input  logic [DATA_WIDTH-1:0]     mc_rdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = ADDR_WIDTH + 1 + DATA_WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    RETIRE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  timeout_err_q, timeout_err_d;
  logic [EW-1:0]         mem_q [DEPTH];
  logic [EW-1:0]         head;
  logic                  push, pop;

  assign req_ready   = (count_q < FULL_CNT);
  assign push        = req_valid && req_ready;
  assign head        = mem_q[rd_ptr_q];
  assign mc_addr     = head[EW-1 -: ADDR_WIDTH];
  assign mc_we       = head[DATA_WIDTH];
  assign mc_wdata    = head[DATA_WIDTH-1:0];
  assign mc_valid    = (state_q == BUSY);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign count       = count_q;
  assign timeout_err = timeout_err_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    timeout_err_d = timeout_err_q;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = BUSY;
          timer_d = '0;
        end
      end
      BUSY: begin
        // A completion in the timeout cycle wins over the timeout.
        if (mc_done) begin
          state_d = RETIRE;
          if (!mc_we) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mc_rdata;
          end
        end else if (timer_q == TIMER_MAX) begin
          state_d       = RETIRE;
          timeout_err_d = 1'b1;
          if (!mc_we) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RETIRE: begin
        pop     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {req_addr, req_we, req_wdata};
  end

endmodule

`default_nettype wire
